// File: rtl/da_audio_pkg.sv
// Shared audio constants and types for the DAC-side serial blocks.
package da_audio_pkg;

    localparam int I2S_SLOT_BITS   = 32;
    localparam int I2S_SAMPLE_BITS = 24;

    typedef struct packed {
        logic [I2S_SAMPLE_BITS-1:0] left;
        logic [I2S_SAMPLE_BITS-1:0] right;
    } stereo_t;

    // The divider needs an even count of at least 2, so odd ratios round up.
    function automatic int bck_div_for(input int mclk_per_bck);
        int d;
        d = (mclk_per_bck < 2) ? 2 : mclk_per_bck;
        return d + (d % 2);
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between the audio producer and the I2S transmitter.
interface i2s_tx_serializer_if #(
    parameter int SAMPLE_BITS = da_audio_pkg::I2S_SAMPLE_BITS
);
    logic [SAMPLE_BITS-1:0] in_left;
    logic [SAMPLE_BITS-1:0] in_right;
    logic                   in_valid;
    logic                   in_ready;

    modport master (output in_left, output in_right, output in_valid, input in_ready);
    modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: free-running div_cnt, registered bck, and a strobe on the
// last clkin cycle of each BCK period (the cycle whose edge drops bck).
module i2s_bck_gen #(
    parameter int BCK_DIV = 4,
    parameter int B       = 8
) (
    input  logic clkin,
    input  logic reset,
    output logic bck,
    output logic fall_evt
);
    localparam logic [B-1:0] DIV_LAST = B'(BCK_DIV - 1);
    localparam logic [B-1:0] DIV_HALF = B'(BCK_DIV / 2);

    logic [B-1:0] div_cnt_q, div_cnt_d;
    logic         bck_q, bck_d;

    assign fall_evt = (div_cnt_q == DIV_LAST);
    assign bck      = bck_q;

    always_comb begin
        div_cnt_d = fall_evt ? '0 : div_cnt_q + 1'b1;
        bck_d     = (div_cnt_d >= DIV_HALF);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            div_cnt_q <= DIV_LAST;
            bck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bck_q     <= bck_d;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one pending stereo pair plus the pair being shifted out,
// MSB-first with a one-BCK delay after each LRCK edge and zero padding.
module i2s_tx_serializer
    import da_audio_pkg::*;
#(
    parameter int BCK_DIV     = bck_div_for(4),
    parameter int SLOT_BITS   = I2S_SLOT_BITS,
    parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
    parameter int B           = 8
) (
    input  logic               clkin,
    input  logic               reset,
    i2s_tx_serializer_if.slave bus,
    input  logic               clear_underrun,
    output logic               bck,
    output logic               lrck,
    output logic               sdata,
    output logic               underrun
);
    localparam logic [B-1:0] BIT_LAST = B'(2 * SLOT_BITS - 1);
    localparam logic [B-1:0] SLOT_B   = B'(SLOT_BITS);
    localparam logic [B-1:0] SAMP_B   = B'(SAMPLE_BITS);
    localparam logic [SAMPLE_BITS-1:0] ONE = SAMPLE_BITS'(1);

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] left;
        logic [SAMPLE_BITS-1:0] right;
    } pair_t;

    logic                   fall_evt, frame_evt, accept;
    logic [B-1:0]           bit_cnt_q, bit_cnt_d, k;
    logic                   lrck_q, lrck_d, sdata_q, sdata_d;
    logic                   underrun_q, underrun_d;
    logic                   pend_full_q, pend_full_d;
    pair_t                  pend_q, pend_d, word_q, word_d, in_pair;
    logic [SAMPLE_BITS-1:0] cur_word;

    i2s_bck_gen #(.BCK_DIV(BCK_DIV), .B(B)) u_bck_gen (
        .clkin   (clkin),
        .reset   (reset),
        .bck     (bck),
        .fall_evt(fall_evt)
    );

    assign bus.in_ready = !pend_full_q && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign frame_evt    = fall_evt && (bit_cnt_q == BIT_LAST);

    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        lrck_d        = lrck_q;
        sdata_d       = sdata_q;
        underrun_d    = underrun_q;
        pend_full_d   = pend_full_q;
        pend_d        = pend_q;
        word_d        = word_q;
        k             = '0;
        cur_word      = '0;
        in_pair.left  = bus.in_left;
        in_pair.right = bus.in_right;

        // Bit k of a slot carries word[SAMPLE_BITS-k]; k=0 is the I2S delay bit.
        if (fall_evt) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            lrck_d    = (bit_cnt_d >= SLOT_B);
            k         = lrck_d ? bit_cnt_d - SLOT_B : bit_cnt_d;
            cur_word  = lrck_d ? word_q.right : word_q.left;
            sdata_d   = (k != '0) && (k <= SAMP_B)
                        && ((cur_word & (ONE << (SAMP_B - k))) != '0);
        end

        if (clear_underrun) underrun_d = 1'b0;

        // A new underrun in the same cycle as a clear takes precedence.
        if (frame_evt) begin
            if (pend_full_q) begin
                word_d      = pend_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                word_d = in_pair;
            end else begin
                word_d     = '0;
                underrun_d = 1'b1;
            end
        end else if (accept) begin
            pend_d      = in_pair;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            bit_cnt_q   <= BIT_LAST;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            word_q      <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            word_q      <= word_d;
        end
    end

endmodule
